// File: rtl/i2s_clkws_gen_mc.sv
// Multi-channel I2S/TDM serial clock and word-select generator.
// Each channel divides the system clock into SCK, tracks the bit position inside a
// frame of (S+1)*(W+1) bits and drives WS in 50% or pulse (TDM/DSP) form, optionally
// leading the data by one bit (I2S). Configuration is shadowed at frame boundaries,
// so mid-frame changes and disables take effect only once the current frame completes.
//
// Ports (all vectors are per channel, channel n in slice n):
//   clk_i            system clock
//   rst_i            asynchronous active-high reset
//   cfg_en_i         channel enable
//   cfg_div_i        divider D, SCK period = 2*(D+1) clk
//   cfg_word_size_i  bits per word minus 1 (S)
//   cfg_word_num_i   words per frame minus 1 (W)
//   cfg_ws_pulse_i   1 = one-bit WS pulse at frame start, 0 = 50% WS
//   cfg_ws_dly_i     1 = WS leads data by one bit
//   cfg_sync_i       1 = take SCK from channel 0 (bit 0 ignored)
//   sck_o            serial clock
//   ws_o             word select
//   sck_rise_o       strobe in the first cycle SCK is high
//   sck_fall_o       strobe in the first cycle SCK is low after being high
//   frame_o          strobe in the first cycle of a frame (bit position 0)
//   busy_o           channel running
module i2s_clkws_gen_mc #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned DIV_W  = 16,
   parameter int unsigned WSZ_W  = 5,
   parameter int unsigned WNUM_W = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_CH-1:0]          cfg_en_i,
   input  logic [NUM_CH*DIV_W-1:0]    cfg_div_i,
   input  logic [NUM_CH*WSZ_W-1:0]    cfg_word_size_i,
   input  logic [NUM_CH*WNUM_W-1:0]   cfg_word_num_i,
   input  logic [NUM_CH-1:0]          cfg_ws_pulse_i,
   input  logic [NUM_CH-1:0]          cfg_ws_dly_i,
   input  logic [NUM_CH-1:0]          cfg_sync_i,
   output logic [NUM_CH-1:0]          sck_o,
   output logic [NUM_CH-1:0]          ws_o,
   output logic [NUM_CH-1:0]          sck_rise_o,
   output logic [NUM_CH-1:0]          sck_fall_o,
   output logic [NUM_CH-1:0]          frame_o,
   output logic [NUM_CH-1:0]          busy_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // WS level for bit (b_in, w_in); with dly set, the level of the following bit,
   // wrapping into the next frame (where the single-word 50% phase flips).
   function automatic logic ws_calc(input logic [WSZ_W-1:0]  b_in,
                                    input logic [WNUM_W-1:0] w_in,
                                    input logic [WSZ_W-1:0]  s,
                                    input logic [WNUM_W-1:0] w,
                                    input logic              pulse,
                                    input logic              ph_in,
                                    input logic              dly);
      logic [WSZ_W-1:0]  b;
      logic [WNUM_W-1:0] wd;
      logic              ph;
      b  = b_in;
      wd = w_in;
      ph = ph_in;
      if (dly) begin
         if (b == s && wd == w) begin
            b  = '0;
            wd = '0;
            ph = ~ph;
         end else if (b == s) begin
            b  = '0;
            wd = wd + 1'b1;
         end else begin
            b = b + 1'b1;
         end
      end
      if (pulse)         return (b == '0) && (wd == '0);
      else if (w == '0)  return ph;
      else               return wd > (w >> 1);
   endfunction

   logic unused_sync0;
   assign unused_sync0 = cfg_sync_i[0];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [0:0]        state_q, state_d;
      logic [DIV_W-1:0]  div_cnt_q, div_cnt_d, div_sh_q, div_sh_d;
      logic [WSZ_W-1:0]  bit_cnt_q, bit_cnt_d, wsz_sh_q, wsz_sh_d;
      logic [WNUM_W-1:0] word_cnt_q, word_cnt_d, wnum_sh_q, wnum_sh_d;
      logic              pulse_sh_q, pulse_sh_d, dly_sh_q, dly_sh_d, ph_q, ph_d;
      logic              sck_q, sck_d, ws_q, ws_d, rise_q, rise_d;
      logic              fall_q, fall_d, frame_q, frame_d;
      logic              sync_mode, fall_evt;
      logic [DIV_W-1:0]  c_div;
      logic [WSZ_W-1:0]  c_wsz;
      logic [WNUM_W-1:0] c_wnum;

      assign c_div     = cfg_div_i[g*DIV_W +: DIV_W];
      assign c_wsz     = cfg_word_size_i[g*WSZ_W +: WSZ_W];
      assign c_wnum    = cfg_word_num_i[g*WNUM_W +: WNUM_W];
      assign sync_mode = (g != 0) && cfg_sync_i[g];

      always_comb begin
         state_d    = state_q;
         div_cnt_d  = div_cnt_q;
         bit_cnt_d  = bit_cnt_q;
         word_cnt_d = word_cnt_q;
         div_sh_d   = div_sh_q;
         wsz_sh_d   = wsz_sh_q;
         wnum_sh_d  = wnum_sh_q;
         pulse_sh_d = pulse_sh_q;
         dly_sh_d   = dly_sh_q;
         ph_d       = ph_q;
         sck_d      = sck_q;
         ws_d       = ws_q;
         rise_d     = 1'b0;
         fall_d     = 1'b0;
         frame_d    = 1'b0;
         fall_evt   = 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               sck_d = 1'b0;
               ws_d  = 1'b0;
               // A synced channel may only start on channel 0's frame start.
               if (cfg_en_i[g] && (!sync_mode || frame_o[0])) begin
                  state_d    = ST_RUN;
                  div_sh_d   = c_div;
                  wsz_sh_d   = c_wsz;
                  wnum_sh_d  = c_wnum;
                  pulse_sh_d = cfg_ws_pulse_i[g];
                  dly_sh_d   = cfg_ws_dly_i[g];
                  div_cnt_d  = '0;
                  bit_cnt_d  = '0;
                  word_cnt_d = '0;
                  ph_d       = 1'b0;
                  frame_d    = 1'b1;
                  ws_d       = ws_calc('0, '0, c_wsz, c_wnum, cfg_ws_pulse_i[g], 1'b0,
                                       cfg_ws_dly_i[g]);
               end
            end
            ST_RUN: begin
               if (sync_mode) begin
                  sck_d    = sck_o[0];
                  rise_d   = sck_rise_o[0];
                  fall_d   = sck_fall_o[0];
                  fall_evt = sck_fall_o[0];
               end else if (div_cnt_q == div_sh_q) begin
                  div_cnt_d = '0;
                  sck_d     = ~sck_q;
                  rise_d    = ~sck_q;
                  fall_d    = sck_q;
                  fall_evt  = sck_q;
               end else begin
                  div_cnt_d = div_cnt_q + 1'b1;
               end
               if (fall_evt) begin
                  if (bit_cnt_q == wsz_sh_q && word_cnt_q == wnum_sh_q) begin
                     bit_cnt_d  = '0;
                     word_cnt_d = '0;
                     div_cnt_d  = '0;
                     if (cfg_en_i[g]) begin
                        div_sh_d   = c_div;
                        wsz_sh_d   = c_wsz;
                        wnum_sh_d  = c_wnum;
                        pulse_sh_d = cfg_ws_pulse_i[g];
                        dly_sh_d   = cfg_ws_dly_i[g];
                        ph_d       = ~ph_q;
                        frame_d    = 1'b1;
                        ws_d       = ws_calc('0, '0, c_wsz, c_wnum, cfg_ws_pulse_i[g], ~ph_q,
                                             cfg_ws_dly_i[g]);
                     end else begin
                        state_d = ST_IDLE;
                        sck_d   = 1'b0;
                        ws_d    = 1'b0;
                     end
                  end else begin
                     if (bit_cnt_q == wsz_sh_q) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + 1'b1;
                     end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                     end
                     ws_d = ws_calc(bit_cnt_d, word_cnt_d, wsz_sh_q, wnum_sh_q, pulse_sh_q, ph_q,
                                    dly_sh_q);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            div_sh_q   <= '0;
            wsz_sh_q   <= '0;
            wnum_sh_q  <= '0;
            pulse_sh_q <= 1'b0;
            dly_sh_q   <= 1'b0;
            ph_q       <= 1'b0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            frame_q    <= 1'b0;
         end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            div_sh_q   <= div_sh_d;
            wsz_sh_q   <= wsz_sh_d;
            wnum_sh_q  <= wnum_sh_d;
            pulse_sh_q <= pulse_sh_d;
            dly_sh_q   <= dly_sh_d;
            ph_q       <= ph_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            frame_q    <= frame_d;
         end
      end

      assign sck_o[g]      = sck_q;
      assign ws_o[g]       = ws_q;
      assign sck_rise_o[g] = rise_q;
      assign sck_fall_o[g] = fall_q;
      assign frame_o[g]    = frame_q;
      assign busy_o[g]     = (state_q == ST_RUN);
   end

endmodule
